// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED decoder and the future encoder check path:
// codeword geometry helpers and the error-class encoding.
package ecc_pkg;

    localparam int MAX_CW = 512;

    typedef enum logic [1:0] {
        NONE,
        SGL,
        DBL
    } err_class_e;

    function automatic int cw_width(input int data_w, input int chk_w);
        return data_w + chk_w;
    endfunction

    // Data bits fill the non-power-of-two positions from 3 upwards, LSB first.
    function automatic int data_pos(input int i);
        int pos;
        int idx;
        pos = 0;
        idx = 0;
        for (int p = 3; p < MAX_CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (idx == i && pos == 0) begin
                    pos = p;
                end
                idx++;
            end
        end
        return pos;
    endfunction

    function automatic logic [MAX_CW-1:0] syn_mask(input int k, input int cw_w);
        logic [MAX_CW-1:0] m;
        m = '0;
        for (int p = 1; p < cw_w; p++) begin
            if (((p >> k) & 1) != 0) begin
                m[p] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/secded_syn_calc.sv
// Combinational syndrome of an extended Hamming codeword: Hamming bits in the
// low positions, overall parity in the top bit.
module secded_syn_calc
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 7,
    localparam int CW_W  = cw_width(DATA_W, CHK_W)
) (
    input  logic [CW_W-1:0]  cw,
    output logic [CHK_W-1:0] syn
);

    for (genvar k = 0; k < CHK_W - 1; k++) begin : g_ham
        localparam logic [MAX_CW-1:0] MASK_FULL = syn_mask(k, CW_W);
        localparam logic [CW_W-1:0]   MASK      = MASK_FULL[CW_W-1:0];
        assign syn[k] = ^(cw & MASK);
    end

    assign syn[CHK_W-1] = ^cw;

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control.
// Define ECC_ERR_CNT_EN to build the saturating single/double error counters.
module secded_dec_pipe
    import ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 7,
    parameter int CNT_W  = 16,
    localparam int CW_W  = cw_width(DATA_W, CHK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   in,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out,
    output logic [CHK_W-1:0]  syn,
    output logic              err,
    output logic              sgl,
    output logic              dbl,
    output logic              out_vld,
    input  logic              out_rdy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    if ((2 ** (CHK_W - 1)) < CW_W || CW_W > MAX_CW) begin : g_param_check
        $error("secded_dec_pipe: CHK_W too small for DATA_W");
    end

    localparam logic [CW_W-1:0] ONE = 1;

    logic             v1;
    logic             v2;
    logic             acc1;
    logic             acc2;
    logic [CW_W-1:0]  cw1;
    logic [CHK_W-1:0] syn_comb;
    logic [CHK_W-1:0] syn1;

    assign acc2    = !v2 || out_rdy;
    assign acc1    = !v1 || acc2;
    assign in_rdy  = acc1;
    assign out_vld = v2;

    secded_syn_calc #(
        .DATA_W(DATA_W),
        .CHK_W (CHK_W)
    ) u_syn (
        .cw (in),
        .syn(syn_comb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            cw1  <= '0;
            syn1 <= '0;
        end else if (acc1) begin
            v1 <= in_vld;
            if (in_vld) begin
                cw1  <= in;
                syn1 <= syn_comb;
            end
        end
    end

    logic [CHK_W-2:0]  ham;
    logic              par;
    err_class_e        cls;
    logic [CW_W-1:0]   fixed;
    logic [DATA_W-1:0] data_fix;

    // A syndrome pointing past the last position cannot be a single flip.
    always_comb begin
        ham   = syn1[CHK_W-2:0];
        par   = syn1[CHK_W-1];
        cls   = NONE;
        fixed = cw1;
        if (par) begin
            if (int'(ham) < CW_W) begin
                cls   = SGL;
                fixed = cw1 ^ (ONE << ham);
            end else begin
                cls = DBL;
            end
        end else if (ham != '0) begin
            cls = DBL;
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        localparam int POS = data_pos(i);
        assign data_fix[i] = fixed[POS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            out <= '0;
            syn <= '0;
            err <= 1'b0;
            sgl <= 1'b0;
            dbl <= 1'b0;
        end else if (acc2) begin
            v2 <= v1;
            if (v1) begin
                out <= data_fix;
                syn <= syn1;
                err <= (cls != NONE);
                sgl <= (cls == SGL);
                dbl <= (cls == DBL);
            end
        end
    end

`ifdef ECC_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic hs;
    assign hs = v2 && out_rdy;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (cnt_clr) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else begin
            if (hs && sgl && sgl_cnt != CNT_MAX) begin
                sgl_cnt <= sgl_cnt + CNT_W'(1);
            end
            if (hs && dbl && dbl_cnt != CNT_MAX) begin
                dbl_cnt <= dbl_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sgl_cnt        = '0;
    assign dbl_cnt        = '0;
`endif

endmodule

// File: doc/secded_dec_pipe.md
# secded_dec_pipe

Parametrised, pipelined SECDED (extended Hamming) decoder. It is the successor to the fixed 32-bit combinational decoder: data width and check width are generic, flow control is valid/ready with backpressure, and optional saturating single/double error counters are included. It sits between memory read data and the consumer, correcting single-bit errors and flagging double-bit errors on every word.

## Interface
- DATA_W, 32: data bits per word.
- CHK_W, 7: check bits, including the overall parity bit. Elaboration fails unless 2^(CHK_W-1) >= DATA_W+CHK_W.
- CNT_W, 16: width of each error counter.
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN  input  DATA_W+CHK_W  received codeword.
- IN_VLD  input  1  IN is valid.
- IN_RDY  output  1  decoder accepts IN this cycle.
- OUT  output  DATA_W  corrected data.
- SYN  output  CHK_W  syndrome; bit CHK_W-1 is overall parity, the low bits are the Hamming syndrome.
- ERR, SGL, DBL  output  1 each  any error / corrected single error / uncorrectable error.
- OUT_VLD  output  1  OUT/SYN/flags are valid.
- OUT_RDY  input  1  consumer takes the output.
- CNT_CLR  input  1  synchronous clear of both counters (ECC_ERR_CNT_EN only).
- SGL_CNT, DBL_CNT  output  CNT_W each  saturating error counts (ECC_ERR_CNT_EN only).

## Operation
- Codeword layout, using codeword positions 0..DATA_W+CHK_W-1:
  - Position 0 is the overall parity bit.
  - Positions 2^k (k=0..CHK_W-2) are Hamming check bits.
  - The remaining positions, in ascending order, carry data LSB first (position 3 = data[0], 5 = data[1], ...).
- Syndrome:
  - Hamming syndrome bit k = XOR of all positions p>=1 with p[k]=1.
  - Overall parity P = XOR of all positions.
- Classification:
  - Syndrome 0 and P=0: no error. ERR=SGL=DBL=0.
  - P=1 and Hamming syndrome = 0: error in the parity bit itself. SGL=1; data unchanged.
  - P=1 and Hamming syndrome in 1..DATA_W+CHK_W-1: flip that position. SGL=1.
  - P=1 and Hamming syndrome beyond the last position: treat as uncorrectable. DBL=1.
  - P=0 and Hamming syndrome != 0: uncorrectable. DBL=1; data passed through uncorrected.
  - ERR = SGL | DBL. SGL and DBL are never both 1.
- Pipeline:
  - Stage 1 registers the codeword and syndrome.
  - Stage 2 registers the corrected data and flags.
  - Each stage holds its contents while blocked.
- Counters:
  - Increment on an output handshake (OUT_VLD & OUT_RDY) with SGL or DBL respectively.
  - Saturate at 2^CNT_W-1.
  - CNT_CLR wins over a simultaneous increment (result 0).

## Timing
- Latency: 2 cycles from IN handshake to OUT_VLD when there is no backpressure. Throughput is 1 word/cycle.
- Ready chain:
  - acc2 = !v2 | OUT_RDY.
  - acc1 = !v1 | acc2.
  - IN_RDY = acc1.
  - This is a combinational path from OUT_RDY to IN_RDY; it is intentional.
- Stability: while OUT_VLD=1 and OUT_RDY=0, OUT, SYN and the flags stay stable and no word is lost or duplicated.
- Reset values (asynchronous, mid-operation included):
  - All valid bits are cleared and in-flight words are dropped.
  - OUT_VLD=0, OUT=0, SYN=0, ERR=SGL=DBL=0, counters=0.
  - IN_RDY=1 in the first cycle after RST_N deasserts.
- Input data: IN is ignored when IN_VLD=0 or IN_RDY=0.

## Configuration
- ECC_ERR_CNT_EN defined: the counters and CNT_CLR are present as specified above.
- ECC_ERR_CNT_EN undefined:
  - No counter flops exist.
  - SGL_CNT and DBL_CNT are tied to 0 and CNT_CLR is ignored.
  - The port list is unchanged.
  - Decode behaviour and timing are identical.

## Structure
- Package ecc_pkg contains:
  - The function that computes the position of data bit i.
  - The function that computes the syndrome mask of each Hamming bit.
  - The function that computes CW_W = DATA_W+CHK_W.
  - An error-class enum (NONE, SGL, DBL).
- Sub-module secded_syn_calc: purely combinational, codeword in, CHK_W syndrome out. It is shared with the future encoder check path.

## Test plan
- DATA_W=32, IN=39'b0 with OUT_RDY=1 -> 2 cycles later OUT=0, SYN=0, ERR=SGL=DBL=0.
- Zero codeword with position 5 flipped -> SYN=7'b1000101, SGL=1, ERR=1, OUT=0 (data[1] corrected).
- Zero codeword with positions 3 and 5 flipped -> SYN=7'b0000110, DBL=1, SGL=0, OUT=32'h3.
- Zero codeword with only position 0 flipped -> SYN=7'b1000000, SGL=1, OUT=0.
- Stream 10 words while OUT_RDY toggles 1,0,0,1 -> every word emerges exactly once, in order; outputs are stable during stalls; IN_RDY drops only when both stages are full and OUT_RDY=0.
- With ECC_ERR_CNT_EN and CNT_W=2:
  - 5 single-error words -> SGL_CNT saturates at 3.
  - CNT_CLR asserted together with a DBL handshake -> DBL_CNT=0.
  - RST_N pulsed mid-stream -> OUT_VLD=0 and counters=0 immediately.
